// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU vs. 2-entry load FIFO onto one register-file write port.
// Optional WB_LD_BYPASS_EN lets a lone load skip the FIFO when nothing else competes.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_type,
  output logic        ld_ready,
  output logic [2:0]  rf_rwe,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] pending_mask
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  typ;
  } ld_entry_t;

  ld_entry_t          fifo_q [2];
  ld_entry_t          fifo_d [2];
  logic [1:0]         count_q, count_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [2:0]         rf_rwe_q, rf_rwe_d;
  logic [4:0]         rf_addr_q, rf_addr_d;
  logic [31:0]        rf_data_q, rf_data_d;
  logic [31:0]        pending_mask_q, pending_mask_d;

  logic fifo_empty, force_ld, push, do_push, pop, alu_gnt, byp_gnt;

  // Write code for a load: x0 and undefined type codes suppress the write
  function automatic logic [2:0] ld_code(input logic [4:0] rd, input logic [2:0] typ);
    if (rd == 5'd0 || typ == 3'd0 || typ > 3'd5) return 3'd0;
    return typ;
  endfunction

  assign fifo_empty = (count_q == 2'd0);
  assign force_ld   = !fifo_empty && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign ld_ready   = ~reset & (count_q != 2'd2);
  assign alu_stall  = ~reset & alu_valid & force_ld;

  always_comb begin
    fifo_d         = fifo_q;
    count_d        = count_q;
    starve_cnt_d   = starve_cnt_q;
    rf_rwe_d       = 3'd0;
    rf_addr_d      = 5'd0;
    rf_data_d      = 32'd0;
    pending_mask_d = 32'd0;
    pop            = 1'b0;
    alu_gnt        = 1'b0;
    byp_gnt        = 1'b0;
    push           = ld_valid & (count_q != 2'd2);

    if (force_ld)        pop = 1'b1;
    else if (alu_valid)  alu_gnt = 1'b1;
    else if (!fifo_empty) pop = 1'b1;
`ifdef WB_LD_BYPASS_EN
    else if (ld_valid)   byp_gnt = 1'b1;
`endif

    do_push = push & ~byp_gnt;

    if (alu_gnt) begin
      rf_rwe_d  = (alu_rd == 5'd0) ? 3'd0 : 3'd1;
      rf_addr_d = alu_rd;
      rf_data_d = alu_data;
    end else if (pop) begin
      rf_rwe_d  = ld_code(fifo_q[0].rd, fifo_q[0].typ);
      rf_addr_d = fifo_q[0].rd;
      rf_data_d = fifo_q[0].data;
    end else if (byp_gnt) begin
      rf_rwe_d  = ld_code(ld_rd, ld_type);
      rf_addr_d = ld_rd;
      rf_data_d = ld_data;
    end

    // Starvation counter only tracks ALU wins over a waiting load
    if (fifo_empty || pop)
      starve_cnt_d = '0;
    else if (alu_gnt && starve_cnt_q != CNT_W'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + CNT_W'(1);

    // Head is always slot 0; a pop shifts slot 1 down before the push lands
    if (pop) fifo_d[0] = fifo_q[1];
    if (do_push) begin
      if (count_q == 2'(pop)) fifo_d[0] = '{rd: ld_rd, data: ld_data, typ: ld_type};
      else                    fifo_d[1] = '{rd: ld_rd, data: ld_data, typ: ld_type};
    end
    count_d = count_q + 2'(do_push) - 2'(pop);

    for (int i = 0; i < 2; i++) begin
      if (2'(i) < count_d && fifo_d[i].rd != 5'd0)
        pending_mask_d[fifo_d[i].rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
      count_q        <= 2'd0;
      starve_cnt_q   <= '0;
      rf_rwe_q       <= 3'd0;
      rf_addr_q      <= 5'd0;
      rf_data_q      <= 32'd0;
      pending_mask_q <= 32'd0;
    end else begin
      fifo_q         <= fifo_d;
      count_q        <= count_d;
      starve_cnt_q   <= starve_cnt_d;
      rf_rwe_q       <= rf_rwe_d;
      rf_addr_q      <= rf_addr_d;
      rf_data_q      <= rf_data_d;
      pending_mask_q <= pending_mask_d;
    end
  end

  assign rf_rwe       = rf_rwe_q;
  assign rf_addr      = rf_addr_q;
  assign rf_data      = rf_data_q;
  assign pending_mask = pending_mask_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;

  localparam int unsigned LIMIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_stall;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic [2:0]  ld_type = 3'd0;
  logic        ld_ready;
  logic [2:0]  rf_rwe;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pending_mask;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_type(ld_type), .ld_ready(ld_ready),
    .rf_rwe(rf_rwe), .rf_addr(rf_addr), .rf_data(rf_data), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  typ;
  } ent_t;

  ent_t        q[$];
  ent_t        head;
  int          starve_m = 0;
  int          sz;
  bit          m_force, m_push, m_pop, m_alu, m_byp;
  logic [2:0]  e_rwe = 3'd0;
  logic [4:0]  e_addr = 5'd0;
  logic [31:0] e_data = 32'd0;
  bit          started = 1'b0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [2:0] wr_code(input logic [4:0] rd, input logic [2:0] typ);
    if (rd == 5'd0) return 3'd0;
    if (typ >= 3'd1 && typ <= 3'd5) return typ;
    return 3'd0;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    foreach (q[i]) if (q[i].rd != 5'd0) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances one transaction step per rising edge
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      q.delete();
      starve_m = 0;
      e_rwe = 3'd0; e_addr = 5'd0; e_data = 32'd0;
    end else begin
      sz      = q.size();
      m_force = (sz > 0) && (starve_m == LIMIT);
      m_push  = ld_valid && (sz < 2);
      m_pop = 1'b0; m_alu = 1'b0; m_byp = 1'b0;
      if (m_force) m_pop = 1'b1;
      else if (alu_valid) m_alu = 1'b1;
      else if (sz > 0) m_pop = 1'b1;
`ifdef WB_LD_BYPASS_EN
      else if (ld_valid) m_byp = 1'b1;
`endif
      e_rwe = 3'd0; e_addr = 5'd0; e_data = 32'd0;
      if (m_alu) begin
        e_rwe = (alu_rd == 5'd0) ? 3'd0 : 3'd1; e_addr = alu_rd; e_data = alu_data;
      end else if (m_pop) begin
        head = q.pop_front();
        e_rwe = wr_code(head.rd, head.typ); e_addr = head.rd; e_data = head.data;
      end else if (m_byp) begin
        e_rwe = wr_code(ld_rd, ld_type); e_addr = ld_rd; e_data = ld_data;
      end
      if (sz == 0 || m_pop) starve_m = 0;
      else if (m_alu && starve_m < LIMIT) starve_m = starve_m + 1;
      if (m_push && !m_byp) q.push_back('{ld_rd, ld_data, ld_type});
    end
  end

  // Every-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_rf_rwe", 32'(rf_rwe), 32'(e_rwe));
      if (e_rwe != 3'd0) begin
        chk("cyc_rf_addr", 32'(rf_addr), 32'(e_addr));
        chk("cyc_rf_data", rf_data, e_data);
      end
      chk("cyc_pending_mask", pending_mask, model_mask());
      chk("cyc_ld_ready", 32'(ld_ready), 32'(!reset && q.size() < 2));
      chk("cyc_alu_stall", 32'(alu_stall),
          32'(!reset && alu_valid && q.size() > 0 && starve_m == LIMIT));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with a load offered
    reset = 1'b1; ld_valid = 1'b1; ld_rd = 5'd3; ld_type = 3'd1; ld_data = 32'h5;
    tick();
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_rf_rwe", 32'(rf_rwe), 0);
    chk("rst_mask", pending_mask, 0);
    tick();
    chk("rst2_ld_ready", 32'(ld_ready), 0);
    chk("rst2_rf_addr", 32'(rf_addr), 0);
    chk("rst2_rf_data", rf_data, 0);
    reset = 1'b0; ld_valid = 1'b0;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
    #1 chk("alu_stall", 32'(alu_stall), 0);
    tick();
    chk("alu_rwe", 32'(rf_rwe), 1);
    chk("alu_addr", 32'(rf_addr), 5);
    chk("alu_data", rf_data, 32'h12345678);
    alu_valid = 1'b0;
    tick();
    chk("idle_rwe", 32'(rf_rwe), 0);

    // ALU write to x0
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1 chk("x0_stall", 32'(alu_stall), 0);
    tick();
    chk("x0_rwe", 32'(rf_rwe), 0);
    alu_valid = 1'b0;
    tick();

    // Starvation: lbu rd=7 waits behind a continuous ALU stream
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_type = 3'd5; ld_data = 32'hA5;
    tick();
    ld_valid = 1'b0;
    chk("starve_mask", pending_mask, 32'h80);
    chk("starve_alu0", 32'(rf_rwe), 1);
    #1 chk("starve_stall1", 32'(alu_stall), 0);
    tick();
    #1 chk("starve_stall2", 32'(alu_stall), 0);
    tick();
    #1 chk("starve_stall3", 32'(alu_stall), 1);
    tick();
    chk("starve_rwe", 32'(rf_rwe), 5);
    chk("starve_addr", 32'(rf_addr), 7);
    chk("starve_data", rf_data, 32'hA5);
    chk("starve_mask_clr", pending_mask, 0);
    #1 chk("starve_stall_clr", 32'(alu_stall), 0);
    tick();
    chk("starve_alu_after", 32'(rf_rwe), 1);
    alu_valid = 1'b0;
    tick();

    // FIFO fills behind a busy ALU, drains rd 3 then rd 4
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_type = 3'd1; ld_data = 32'h33;
    tick();
    ld_rd = 5'd4; ld_type = 3'd2; ld_data = 32'h44;
    #1 chk("full_ready1", 32'(ld_ready), 1);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("full_ready0", 32'(ld_ready), 0);
    chk("full_mask", pending_mask, 32'h18);
    chk("full_stall0", 32'(alu_stall), 0);
    tick();
    #1 chk("full_stall_a", 32'(alu_stall), 1);
    tick();
    chk("full_pop3_rwe", 32'(rf_rwe), 1);
    chk("full_pop3_addr", 32'(rf_addr), 3);
    chk("full_mask_10", pending_mask, 32'h10);
    tick();
    tick();
    #1 chk("full_stall_b", 32'(alu_stall), 1);
    tick();
    chk("full_pop4_rwe", 32'(rf_rwe), 2);
    chk("full_pop4_addr", 32'(rf_addr), 4);
    chk("full_mask_0", pending_mask, 0);
    alu_valid = 1'b0;
    tick();

    // Loads only: bad type, same rd twice, x0, lhu; exercises push+pop together
    ld_valid = 1'b1; ld_rd = 5'd10; ld_type = 3'd7; ld_data = 32'h70;
    tick();
    ld_rd = 5'd10; ld_type = 3'd3; ld_data = 32'h0B;
    tick();
    ld_rd = 5'd0; ld_type = 3'd1; ld_data = 32'hDEAD;
    tick();
    ld_rd = 5'd12; ld_type = 3'd4; ld_data = 32'hC;
    tick();
    ld_rd = 5'd13; ld_type = 3'd0; ld_data = 32'hD;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    repeat (4) tick();

    // Lone lw rd=9: bypass writes one cycle sooner than the FIFO path
    ld_valid = 1'b1; ld_rd = 5'd9; ld_type = 3'd1; ld_data = 32'h99;
    tick();
    ld_valid = 1'b0;
`ifdef WB_LD_BYPASS_EN
    chk("byp_rwe", 32'(rf_rwe), 1);
    chk("byp_addr", 32'(rf_addr), 9);
    chk("byp_mask", pending_mask, 0);
    tick();
`else
    chk("nobyp_rwe_n1", 32'(rf_rwe), 0);
    chk("nobyp_mask", pending_mask, 32'h200);
    tick();
    chk("nobyp_rwe_n2", 32'(rf_rwe), 1);
    chk("nobyp_addr", 32'(rf_addr), 9);
`endif
    tick();

    // Reset mid-operation drops buffered loads
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    ld_valid = 1'b1; ld_rd = 5'd13; ld_type = 3'd1; ld_data = 32'h13;
    tick();
    ld_rd = 5'd14; ld_data = 32'h14;
    tick();
    ld_valid = 1'b0; reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(ld_ready), 0);
    chk("mid_rst_stall", 32'(alu_stall), 0);
    tick();
    reset = 1'b0; alu_valid = 1'b0;
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_rwe", 32'(rf_rwe), 0);
    repeat (3) tick();
    chk("mid_rst_no_write", 32'(rf_rwe), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2: consecutive ALU grants tolerated while a load waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_rd / alu_data  input  5 / 32  ALU destination register and result.
REQ-006 alu_stall  output  1  ALU request refused this cycle; ALU holds its request.
REQ-007 ld_valid  input  1  load-unit writeback request.
REQ-008 ld_rd / ld_data / ld_type  input  5 / 32 / 3  load destination, data, write code (1 lw, 2 lh, 3 lb, 4 lhu, 5 lbu).
REQ-009 ld_ready  output  1  load FIFO can accept; a load transfers when ld_valid & ld_ready.
REQ-010 rf_rwe / rf_addr / rf_data  output  3 / 5 / 32  register-file write port: code, Addr_D, Data_D.
REQ-011 pending_mask  output  32  bit n set while a load targeting xn is buffered.

Function
REQ-012 Write port outputs are registered; a grant in cycle N appears on rf_* in cycle N+1 for exactly one cycle.
REQ-013 rf_rwe is 0 in any cycle without a grant; an ALU grant drives rf_rwe=1.
REQ-014 A load grant drives rf_rwe=ld_type of the granted entry; ld_type 0, 6 or 7 is written as rf_rwe=0.
REQ-015 Any grant with destination x0 drives rf_rwe=0; the request is still consumed.
REQ-016 Load FIFO: 2 entries {rd, data, type}, in-order; ld_ready = (count < 2), from registered count.
REQ-017 Push and pop in the same cycle are permitted; count remains unchanged.
REQ-018 force = FIFO non-empty & starve_cnt == STARVE_LIMIT; derived only from registered state.
REQ-019 Grant priority per cycle: force -> pop load; else alu_valid -> ALU; else FIFO non-empty -> pop load; else none.
REQ-020 alu_stall = alu_valid & force.
REQ-021 starve_cnt increments (saturating at STARVE_LIMIT) when the FIFO is non-empty and ALU is granted; clears on any load pop or when the FIFO is empty.
REQ-022 pending_mask is the OR of one-hot(rd) over valid FIFO entries, x0 excluded; updated the cycle after push/pop.
REQ-023 A load pushed in cycle N is never granted before cycle N+1 (FIFO path); writeback to the register file is no earlier than N+2.
REQ-024 Two loads to the same rd are written in arrival order.

Reset
REQ-025 On reset, FIFO count=0, starve_cnt=0, rf_rwe=0, rf_addr=0, rf_data=0, pending_mask=0.
REQ-026 Reset during operation discards buffered loads; no write is issued for them.
REQ-027 During reset, ld_ready=0 and alu_stall=0.

Configuration
REQ-028 Macro WB_LD_BYPASS_EN defined: a load with ld_valid, FIFO empty, alu_valid=0 is granted directly in the same cycle (rf_* valid at N+1); it is not pushed and does not set pending_mask.
REQ-029 WB_LD_BYPASS_EN undefined: every load passes through the FIFO per REQ-023.

Verification
REQ-030 Reset: assert reset 2 cycles with ld_valid=1 -> ld_ready=0, rf_rwe=0, pending_mask=0.
REQ-031 ALU only: alu_valid, rd=5, data=0x12345678 -> next cycle rf_rwe=1, rf_addr=5, rf_data=0x12345678, alu_stall=0.
REQ-032 Starvation: load lbu rd=7 pushed, ALU valid continuously -> 2 ALU writes, then alu_stall=1 for one cycle and rf_rwe=5, rf_addr=7.
REQ-033 Full FIFO: 2 loads (rd=3, rd=4) pushed while ALU busy -> ld_ready=0, pending_mask=0x18; writes occur rd 3 then rd 4, mask returns to 0.
REQ-034 x0: ALU rd=0 data=0xFFFFFFFF -> rf_rwe=0 next cycle, no stall.
REQ-035 Bypass: lw rd=9, FIFO empty, no ALU -> with WB_LD_BYPASS_EN rf_rwe=1 at N+1; without, at N+2.
